// File: rtl/cpu_pkg.sv
// Shared constants for the 5-stage MIPS core:
// load-type encodings and writeback result-select encodings.
package cpu_pkg;

  localparam logic [2:0] LOAD_LW  = 3'd0;
  localparam logic [2:0] LOAD_LH  = 3'd1;
  localparam logic [2:0] LOAD_LHU = 3'd2;
  localparam logic [2:0] LOAD_LB  = 3'd3;
  localparam logic [2:0] LOAD_LBU = 3'd4;

  localparam logic [1:0] WB_SEL_ALU  = 2'd0;
  localparam logic [1:0] WB_SEL_LOAD = 2'd1;
  localparam logic [1:0] WB_SEL_LINK = 2'd2;

endpackage

// File: rtl/load_extend.sv
// Little-endian byte/half extraction with sign or zero extension; purely combinational.
// Unknown load types fall back to a full-word load.
module load_extend
  import cpu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  load_type,
  output logic [31:0] result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = rdata[7:0];
    case (addr_lo)
      2'd1:    w_byte = rdata[15:8];
      2'd2:    w_byte = rdata[23:16];
      2'd3:    w_byte = rdata[31:24];
      default: w_byte = rdata[7:0];
    endcase
    // Halfword loads ignore addr_lo[0]; misalignment is not trapped here.
    w_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    result = rdata;
    case (load_type)
      LOAD_LB:  result = {{24{w_byte[7]}}, w_byte};
      LOAD_LBU: result = {24'd0, w_byte};
      LOAD_LH:  result = {{16{w_half[15]}}, w_half};
      LOAD_LHU: result = {16'd0, w_half};
      default:  result = rdata;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB register, result select, and register-file write-port arbitration; MEM-to-RF is one cycle.
// The pipeline always wins the port; mul/div results wait in a 1-entry buffer (md_ready low while blocked).
module writeback_stage
  import cpu_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic          m_valid,
  input  logic          m_reg_write,
  input  logic [AW-1:0] m_write_reg,
  input  logic [1:0]    m_mem_to_reg,
  input  logic [2:0]    m_load_type,
  input  logic [1:0]    m_addr_lo,
  input  logic [DW-1:0] m_alu_result,
  input  logic [DW-1:0] m_mem_rdata,
  input  logic [DW-1:0] m_link_pc,
  input  logic          md_valid,
  output logic          md_ready,
  input  logic [AW-1:0] md_write_reg,
  input  logic [DW-1:0] md_data,
  output logic          RegWrite,
  output logic [AW-1:0] Write_register,
  output logic [DW-1:0] Write_data,
  output logic          stall_req
);

  logic          r_wb_valid;
  logic          r_wb_reg_write;
  logic [AW-1:0] r_wb_write_reg;
  logic [DW-1:0] r_wb_data;
  logic          r_buf_full;
  logic [AW-1:0] r_buf_reg;
  logic [DW-1:0] r_buf_data;

  logic [DW-1:0] w_load_val;
  logic [DW-1:0] w_sel_val;
  logic          w_pipe_wr;
  logic          w_drain;
  logic          w_md_xfer;

  load_extend u_load_extend (
    .rdata     (m_mem_rdata),
    .addr_lo   (m_addr_lo),
    .load_type (m_load_type),
    .result    (w_load_val)
  );

  always_comb begin
    case (m_mem_to_reg)
      WB_SEL_LOAD: w_sel_val = w_load_val;
      WB_SEL_LINK: w_sel_val = m_link_pc;
      default:     w_sel_val = m_alu_result;
    endcase
  end

  assign w_pipe_wr = r_wb_valid & r_wb_reg_write;
  assign w_drain   = r_buf_full & ~w_pipe_wr;
  assign md_ready  = ~r_buf_full | w_drain;
  assign w_md_xfer = md_valid & md_ready;
  assign stall_req = r_buf_full & w_pipe_wr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wb_valid     <= 1'b0;
      r_wb_reg_write <= 1'b0;
      r_wb_write_reg <= '0;
      r_wb_data      <= '0;
    end else if (flush) begin
      r_wb_valid <= 1'b0;
    end else if (!stall) begin
      r_wb_valid     <= m_valid;
      r_wb_reg_write <= m_reg_write;
      r_wb_write_reg <= m_write_reg;
      r_wb_data      <= w_sel_val;
    end
  end

  // A fill in the same cycle as a drain simply overwrites the entry and keeps it full.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_buf_full <= 1'b0;
      r_buf_reg  <= '0;
      r_buf_data <= '0;
    end else if (w_md_xfer) begin
      r_buf_full <= 1'b1;
      r_buf_reg  <= md_write_reg;
      r_buf_data <= md_data;
    end else if (w_drain) begin
      r_buf_full <= 1'b0;
    end
  end

  always_comb begin
    RegWrite       = 1'b0;
    Write_register = '0;
    Write_data     = '0;
    if (w_pipe_wr) begin
      RegWrite       = (r_wb_write_reg != '0);
      Write_register = r_wb_write_reg;
      Write_data     = r_wb_data;
    end else if (r_buf_full) begin
      RegWrite       = (r_buf_reg != '0);
      Write_register = r_buf_reg;
      Write_data     = r_buf_data;
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed vector table, multi-cycle corner sequences,
// and a randomized phase against a queue-based reference model.
module tb_writeback_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush;
  logic        m_valid, m_reg_write;
  logic [4:0]  m_write_reg;
  logic [1:0]  m_mem_to_reg;
  logic [2:0]  m_load_type;
  logic [1:0]  m_addr_lo;
  logic [31:0] m_alu_result, m_mem_rdata, m_link_pc;
  logic        md_valid, md_ready;
  logic [4:0]  md_write_reg;
  logic [31:0] md_data;
  logic        RegWrite;
  logic [4:0]  Write_register;
  logic [31:0] Write_data;
  logic        stall_req;

  int checks = 0;
  int errors = 0;

  writeback_stage #(.DW(32), .AW(5)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .m_valid(m_valid), .m_reg_write(m_reg_write), .m_write_reg(m_write_reg),
    .m_mem_to_reg(m_mem_to_reg), .m_load_type(m_load_type), .m_addr_lo(m_addr_lo),
    .m_alu_result(m_alu_result), .m_mem_rdata(m_mem_rdata), .m_link_pc(m_link_pc),
    .md_valid(md_valid), .md_ready(md_ready), .md_write_reg(md_write_reg), .md_data(md_data),
    .RegWrite(RegWrite), .Write_register(Write_register), .Write_data(Write_data),
    .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v, we;
    logic [4:0]  rd;
    logic [1:0]  sel;
    logic [2:0]  lt;
    logic [1:0]  a;
    logic [31:0] alu, rdata, link;
    logic        exp_we;
    logic [4:0]  exp_rd;
    logic [31:0] exp_d;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } md_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_port(input string tag, input logic we, input logic [4:0] rd, input logic [31:0] d);
    chk({tag, "_we"},   {31'd0, RegWrite}, {31'd0, we});
    chk({tag, "_reg"},  {27'd0, Write_register}, {27'd0, rd});
    chk({tag, "_data"}, Write_data, d);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic v, we, input logic [4:0] rd, input logic [1:0] sel,
                              input logic [2:0] lt, input logic [1:0] a, input logic [31:0] alu,
                              input logic [31:0] rdata, link, input logic ewe,
                              input logic [4:0] erd, input logic [31:0] ed);
    vec_t t;
    t.v = v; t.we = we; t.rd = rd; t.sel = sel; t.lt = lt; t.a = a;
    t.alu = alu; t.rdata = rdata; t.link = link;
    t.exp_we = ewe; t.exp_rd = erd; t.exp_d = ed;
    return t;
  endfunction

  task automatic drive_m(input logic v, we, input logic [4:0] rd, input logic [1:0] sel,
                         input logic [2:0] lt, input logic [1:0] a, input logic [31:0] alu,
                         input logic [31:0] rdata, link);
    m_valid = v; m_reg_write = we; m_write_reg = rd; m_mem_to_reg = sel;
    m_load_type = lt; m_addr_lo = a; m_alu_result = alu; m_mem_rdata = rdata; m_link_pc = link;
  endtask

  // Reference result computed from the architectural load/select rules with shifts and masks.
  function automatic logic [31:0] ref_result(input logic [1:0] sel, input logic [2:0] lt,
                                             input logic [1:0] a, input logic [31:0] alu,
                                             input logic [31:0] rdata, input logic [31:0] link);
    logic [31:0] b, h;
    if (sel == 2'd2) return link;
    if (sel != 2'd1) return alu;
    b = (rdata >> (8 * a)) & 32'hFF;
    h = (rdata >> (16 * (a / 2))) & 32'hFFFF;
    case (lt)
      3'd3:    return (b >= 32'h80) ? (b | 32'hFFFFFF00) : b;
      3'd4:    return b;
      3'd1:    return (h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
      3'd2:    return h;
      default: return rdata;
    endcase
  endfunction

  initial begin
    logic        mw_v;
    logic [4:0]  mw_rd;
    logic [31:0] mw_d;
    md_t         mq[$];
    md_t         e;
    logic        pipe, exp_rdy, hold;
    logic        ewe;
    logic [4:0]  erd;
    logic [31:0] ed;

    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    drive_m(0, 0, 0, 0, 0, 0, 0, 0, 0);
    md_valid = 1'b0; md_write_reg = '0; md_data = '0;

    #2;
    chk_port("reset", 0, 0, 0);
    chk("reset_md_ready", {31'd0, md_ready}, 32'd1);
    chk("reset_stall_req", {31'd0, stall_req}, 32'd0);
    #10 rst = 1'b1;

    vecs[0]  = mk(1, 1, 7,  WB_SEL_LOAD, LOAD_LB,  2, 0, 32'h80FF7F01, 0, 1, 7, 32'hFFFFFFFF);
    vecs[1]  = mk(1, 1, 7,  WB_SEL_LOAD, LOAD_LBU, 2, 0, 32'h80FF7F01, 0, 1, 7, 32'h000000FF);
    vecs[2]  = mk(1, 1, 7,  WB_SEL_LOAD, LOAD_LH,  3, 0, 32'h80FF7F01, 0, 1, 7, 32'hFFFF80FF);
    vecs[3]  = mk(1, 1, 7,  WB_SEL_LOAD, LOAD_LHU, 0, 0, 32'h80FF7F01, 0, 1, 7, 32'h00007F01);
    vecs[4]  = mk(1, 1, 7,  WB_SEL_LOAD, LOAD_LH,  1, 0, 32'h80FF7F01, 0, 1, 7, 32'h00007F01);
    vecs[5]  = mk(1, 1, 7,  WB_SEL_LOAD, LOAD_LB,  0, 0, 32'h80FF7F01, 0, 1, 7, 32'h00000001);
    vecs[6]  = mk(1, 1, 7,  WB_SEL_LOAD, LOAD_LBU, 3, 0, 32'h80FF7F01, 0, 1, 7, 32'h00000080);
    vecs[7]  = mk(1, 1, 7,  WB_SEL_LOAD, LOAD_LB,  3, 0, 32'h80FF7F01, 0, 1, 7, 32'hFFFFFF80);
    vecs[8]  = mk(1, 1, 7,  WB_SEL_LOAD, LOAD_LW,  3, 0, 32'h80FF7F01, 0, 1, 7, 32'h80FF7F01);
    vecs[9]  = mk(1, 1, 7,  WB_SEL_LOAD, 3'd6,     1, 0, 32'h80FF7F01, 0, 1, 7, 32'h80FF7F01);
    vecs[10] = mk(1, 1, 12, WB_SEL_ALU,  LOAD_LB,  2, 32'h11112222, 32'h80FF7F01, 0, 1, 12, 32'h11112222);
    vecs[11] = mk(1, 1, 13, 2'd3,        LOAD_LB,  2, 32'h33334444, 32'h80FF7F01, 0, 1, 13, 32'h33334444);
    vecs[12] = mk(1, 1, 31, WB_SEL_LINK, 0, 0, 32'h1, 32'h2, 32'h00400008, 1, 31, 32'h00400008);
    vecs[13] = mk(1, 1, 0,  WB_SEL_LINK, 0, 0, 32'h1, 32'h2, 32'h00400008, 0, 0,  32'h00400008);
    vecs[14] = mk(1, 0, 9,  WB_SEL_ALU,  0, 0, 32'h5, 32'h2, 32'h3, 0, 0, 0);
    vecs[15] = mk(0, 1, 9,  WB_SEL_ALU,  0, 0, 32'h5, 32'h2, 32'h3, 0, 0, 0);

    tick;
    for (int i = 0; i < 16; i++) begin
      drive_m(vecs[i].v, vecs[i].we, vecs[i].rd, vecs[i].sel, vecs[i].lt, vecs[i].a,
              vecs[i].alu, vecs[i].rdata, vecs[i].link);
      tick;
      chk_port($sformatf("vec%0d", i), vecs[i].exp_we, vecs[i].exp_rd, vecs[i].exp_d);
    end

    // Conflict: buffered mul/div result waits behind a pipeline write, then drains on a bubble.
    drive_m(1, 1, 3, WB_SEL_ALU, 0, 0, 32'hAAAA0003, 0, 0);
    md_valid = 1'b1; md_write_reg = 5'd5; md_data = 32'h12345678;
    chk("conf_ready_before", {31'd0, md_ready}, 32'd1);
    tick;
    md_valid = 1'b0;
    chk_port("conf_pipe", 1, 3, 32'hAAAA0003);
    chk("conf_stall_req", {31'd0, stall_req}, 32'd1);
    chk("conf_md_ready", {31'd0, md_ready}, 32'd0);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    drive_m(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk_port("conf_drain", 1, 5, 32'h12345678);
    chk("conf_drain_stall_req", {31'd0, stall_req}, 32'd0);
    chk("conf_drain_ready", {31'd0, md_ready}, 32'd1);
    tick;
    chk_port("conf_idle", 0, 0, 0);

    // Back-to-back mul/div results with an idle pipeline.
    for (int i = 0; i < 3; i++) begin
      md_valid = 1'b1; md_write_reg = 5'(10 + i); md_data = 32'hD0000000 + 32'(i);
      tick;
      chk_port($sformatf("b2b%0d", i), 1, 5'(10 + i), 32'hD0000000 + 32'(i));
      chk($sformatf("b2b%0d_ready", i), {31'd0, md_ready}, 32'd1);
    end
    md_valid = 1'b0;
    tick;
    chk_port("b2b_end", 0, 0, 0);

    // Stall holds MEM/WB; flush wins over stall.
    drive_m(1, 1, 9, WB_SEL_ALU, 0, 0, 32'hCAFE0009, 0, 0);
    tick;
    chk_port("stall_pre", 1, 9, 32'hCAFE0009);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_m(1, 1, 5'(4 + i), WB_SEL_ALU, 0, 0, 32'h44440000 + 32'(i), 0, 0);
      tick;
      chk_port($sformatf("stall%0d", i), 1, 9, 32'hCAFE0009);
    end
    flush = 1'b1;
    tick;
    chk("stall_flush_we", {31'd0, RegWrite}, 32'd0);
    stall = 1'b0; flush = 1'b0;
    drive_m(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick;

    // Asynchronous reset with the buffer full and MEM/WB writing.
    drive_m(1, 1, 3, WB_SEL_ALU, 0, 0, 32'hAAAA0003, 0, 0);
    md_valid = 1'b1; md_write_reg = 5'd5; md_data = 32'h12345678;
    tick;
    md_valid = 1'b0;
    drive_m(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_pre_stall_req", {31'd0, stall_req}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk_port("rst_mid", 0, 0, 0);
    chk("rst_mid_md_ready", {31'd0, md_ready}, 32'd1);
    chk("rst_mid_stall_req", {31'd0, stall_req}, 32'd0);
    #1 rst = 1'b1;
    tick;
    chk_port("rst_after", 0, 0, 0);

    // Randomized phase against the reference model (starts empty: no writer, no buffered result).
    mw_v = 1'b0; mw_rd = '0; mw_d = '0;
    mq.delete();
    hold = 1'b0;
    for (int c = 0; c < 400; c++) begin
      pipe = mw_v;
      exp_rdy = (mq.size() == 0) || !pipe;
      ewe = 1'b0; erd = '0; ed = '0;
      if (pipe) begin
        ewe = (mw_rd != 0); erd = mw_rd; ed = mw_d;
      end else if (mq.size() != 0) begin
        ewe = (mq[0].rd != 0); erd = mq[0].rd; ed = mq[0].d;
      end
      chk_port($sformatf("rnd%0d", c), ewe, erd, ed);
      chk($sformatf("rnd%0d_ready", c), {31'd0, md_ready}, {31'd0, exp_rdy});
      chk($sformatf("rnd%0d_stall_req", c), {31'd0, stall_req},
          {31'd0, (mq.size() != 0) && pipe});

      stall = ($urandom_range(0, 9) < 2);
      flush = ($urandom_range(0, 9) == 0);
      drive_m($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7, 5'($urandom_range(0, 31)),
              2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
              $urandom, $urandom, $urandom);
      if (!hold) begin
        md_valid = ($urandom_range(0, 9) < 4);
        md_write_reg = 5'($urandom_range(0, 31));
        md_data = $urandom;
      end
      hold = md_valid && !exp_rdy;

      if (mq.size() != 0 && !pipe) void'(mq.pop_front());
      if (md_valid && exp_rdy) begin
        e.rd = md_write_reg; e.d = md_data;
        mq.push_back(e);
      end
      if (flush) mw_v = 1'b0;
      else if (!stall) begin
        mw_v = m_valid && m_reg_write;
        mw_rd = m_write_reg;
        mw_d = ref_result(m_mem_to_reg, m_load_type, m_addr_lo, m_alu_result, m_mem_rdata, m_link_pc);
      end
      tick;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
